// File: rtl/rca_multibyte_seq_ctrl.sv
// rca_multibyte_seq_ctrl: adds two WORDS-byte operands one byte per clock
// on a single 8-bit ripple-carry adder, LSB byte first, carrying between
// bytes in a register. done pulses for one cycle when the sum is complete.
module rca_multibyte_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*WORDS-1:0]   a_in,
  input  logic [8*WORDS-1:0]   b_in,
  input  logic                 cin_in,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [7:0]         byte_a;
  logic [7:0]         byte_b;
  logic [8:0]         add_out;

  // Behavioural model of the shared 8-bit ripple-carry adder: {cout, sum}.
  function automatic logic [8:0] rca8(input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic       ci);
    logic [7:0] s;
    logic       c;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // Signed overflow of the full-width add, judged from the operand and sum sign bits.
  function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  // Next-state, byte-slice adder datapath and result assembly.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    byte_a  = a_q[8*idx_q +: 8];
    byte_b  = b_q[8*idx_q +: 8];
    add_out = rca8(byte_a, byte_b, carry_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin_in;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        result_d[8*idx_q +: 8] = add_out[7:0];
        carry_d                = add_out[8];
        if (idx_q == IDX_LAST) begin
          // Hold idx on the top byte so it never wraps.
          cout_d  = add_out[8];
          ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], add_out[7]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_ADD);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
